sixteen_to_four_index_encoder: RTL

- Converts a multi-hot 16-bit vector into a stream of 4-bit indices, one per set bit, lowest index first. It is the inverse of the 4-to-16 decoder.
- The input side accepts one vector per transaction using a valid/ready handshake.
- The output side emits one index per beat, also with valid/ready, and flags the last index of each vector.
- Used to turn decoded select lines or request masks back into binary addresses.

---
 rtl/sixteen_to_four_index_encoder.sv | 112 +++++++++++
 1 files changed

// File: rtl/sixteen_to_four_index_encoder.sv
// Multi-hot to index-stream encoder: accepts a 16-bit vector, then emits one
// 4-bit index per set bit over a valid/ready stream, flagging the final index.
module sixteen_to_four_index_encoder #(
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        in_valid,
    input  logic [15:0] in_vec,
    output logic        in_ready,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [3:0]  out_idx,
    output logic        out_last,
    output logic [4:0]  out_cnt,
    output logic        zero_vec,
    output logic        busy
);

    typedef enum logic {
        IDLE,
        DRAIN
    } state_t;

    state_t      state_q, state_d;
    logic [15:0] pend_q, pend_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        zero_q, zero_d;
    logic [3:0]  idx;
    logic        last;
    logic        accept;

    function automatic logic [4:0] popcount(input logic [15:0] v);
        logic [4:0] n;
        n = '0;
        for (int unsigned i = 0; i < 16; i++) begin
            n = n + {4'b0000, v[i]};
        end
        return n;
    endfunction

    // Priority select over the pending bits; the last match in scan order wins.
    always_comb begin
        idx = '0;
        if (MSB_FIRST) begin
            for (int unsigned i = 0; i < 16; i++) begin
                if (pend_q[i]) idx = 4'(i);
            end
        end else begin
            for (int unsigned i = 16; i > 0; i--) begin
                if (pend_q[i-1]) idx = 4'(i - 1);
            end
        end
    end

    assign last   = (pend_q != '0) && ((pend_q & (pend_q - 16'd1)) == '0);
    assign accept = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        pend_d  = pend_q;
        cnt_d   = cnt_q;
        zero_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (in_vec != '0) begin
                        pend_d  = in_vec;
                        cnt_d   = popcount(in_vec);
                        state_d = DRAIN;
                    end else begin
                        zero_d = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (out_ready) begin
                    pend_d = pend_q & ~(16'd1 << idx);
                    if (last) begin
                        pend_d  = '0;
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            cnt_q   <= '0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            cnt_q   <= cnt_d;
            zero_q  <= zero_d;
        end
    end

    assign in_ready  = (state_q == IDLE) && en;
    assign out_valid = (state_q == DRAIN);
    assign busy      = (state_q == DRAIN);
    assign out_idx   = idx;
    assign out_last  = last;
    assign out_cnt   = cnt_q;
    assign zero_vec  = zero_q;

endmodule
